// File: rtl/t_ff_pkg.sv
// ============================================================================
//  Module   : t_ff_pkg
//  Purpose  : Shared constants for the toggle flip-flop bank: mode and count
//             direction encodings used by the top level and by testbenches.
//  Options  : T_FF_BANK_DOWN_EN (direction constants are only consumed when
//             down counting is built in)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package t_ff_pkg;

    // Operating mode: independent toggle bank or chained binary counter.
    localparam logic TFF_MODE_BANK  = 1'b0;
    localparam logic TFF_MODE_COUNT = 1'b1;

    // Count direction in counter mode.
    localparam logic TFF_DIR_UP     = 1'b0;
    localparam logic TFF_DIR_DOWN   = 1'b1;

endpackage : t_ff_pkg

`default_nettype wire

// File: rtl/t_ff_bank_if.sv
// ============================================================================
//  Module   : t_ff_bank_if
//  Purpose  : Control/data bundle of the toggle flip-flop bank. The master
//             side drives the controls and observes q/tc; the slave side is
//             the bank itself.
//  Options  : T_FF_BANK_DOWN_EN adds the dir signal
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface t_ff_bank_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             mode;
    logic [WIDTH-1:0] t;
    logic             load;
    logic [WIDTH-1:0] d;
`ifdef T_FF_BANK_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] q;
    logic             tc;

`ifdef T_FF_BANK_DOWN_EN
    modport master (
        output en, mode, t, load, d, dir,
        input  q, tc
    );

    modport slave (
        input  en, mode, t, load, d, dir,
        output q, tc
    );
`else
    modport master (
        output en, mode, t, load, d,
        input  q, tc
    );

    modport slave (
        input  en, mode, t, load, d,
        output q, tc
    );
`endif

endinterface : t_ff_bank_if

`default_nettype wire

// File: rtl/t_ff_cell.sv
// ============================================================================
//  Module   : t_ff_cell
//  Purpose  : One bit of toggle state. Priority per edge is rst, then load,
//             then toggle; otherwise the bit holds.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff_cell (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic t,
    input  wire logic load,
    input  wire logic d,
    output logic      q
);

    logic state_q;
    logic state_d;

    // Next state: load beats toggle; no request means hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = d;
        end else if (t) begin
            state_d = ~state_q;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule : t_ff_cell

`default_nettype wire

// File: rtl/t_ff_bank.sv
// ============================================================================
//  Module   : t_ff_bank
//  Purpose  : WIDTH toggle flip-flops usable either as an independent toggle
//             bank (mode 0) or as a synchronous T-FF binary counter with
//             parallel load and a terminal-count flag (mode 1).
//  Options  : T_FF_BANK_DOWN_EN enables the dir input and down counting;
//             without it the counter counts up only.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_ff_bank
    import t_ff_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    t_ff_bank_if.slave  bus
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_chain;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH:0]   w_ones_prefix;
    logic             w_count;
    logic             w_down;
    logic             w_terminal;

    assign w_count = (bus.mode == TFF_MODE_COUNT);

`ifdef T_FF_BANK_DOWN_EN
    logic [WIDTH:0] w_zero_prefix;

    assign w_down = (bus.dir == TFF_DIR_DOWN);

    // Prefix-AND of inverted bits: cell i borrows when all lower bits are 0.
    always_comb begin
        w_zero_prefix    = '0;
        w_zero_prefix[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_zero_prefix[i+1] = w_zero_prefix[i] & ~w_q[i];
        end
    end
`else
    assign w_down = 1'b0;
`endif

    // Prefix-AND of bits: cell i carries when all lower bits are 1.
    always_comb begin
        w_ones_prefix    = '0;
        w_ones_prefix[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones_prefix[i+1] = w_ones_prefix[i] & w_q[i];
        end
    end

    // Per-cell counter toggle picked by direction.
    always_comb begin
        w_chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
`ifdef T_FF_BANK_DOWN_EN
            w_chain[i] = w_down ? w_zero_prefix[i] : w_ones_prefix[i];
`else
            w_chain[i] = w_ones_prefix[i];
`endif
        end
    end

    // Toggle request per cell: chained carry in counter mode, t in bank mode.
    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_toggle[i] = bus.en & (w_count ? w_chain[i] : bus.t[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            t_ff_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .t    (w_toggle[gi]),
                .load (bus.load),
                .d    (bus.d[gi]),
                .q    (w_q[gi])
            );
        end
    endgenerate

    // Terminal value for the active direction: all ones up, all zeros down.
`ifdef T_FF_BANK_DOWN_EN
    assign w_terminal = w_down ? w_zero_prefix[WIDTH] : w_ones_prefix[WIDTH];
`else
    assign w_terminal = w_ones_prefix[WIDTH];
`endif

    // tc is combinational so a cascaded stage can advance on the wrap edge;
    // a load in the same cycle cancels the wrap, so it also masks tc.
    assign bus.tc = w_count & bus.en & ~bus.load & w_terminal;
    assign bus.q  = w_q;

endmodule : t_ff_bank

`default_nettype wire
